// File: rtl/regfile_pclr.sv
// Integer register file with x0 hardwired to zero and a sequential clear.
// After reset, one register is zeroed per cycle. busy_o stalls issue until the clear finishes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing mem[clr_ptr_q] each cycle; reads forced to 0, writes dropped
// ST_READY | normal operation; write port and bypass active
module regfile_pclr #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREG   = 32,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [AW-1:0]   rs1_i,
    input  logic [AW-1:0]   rs2_i,
    input  logic [AW-1:0]   rd_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rv1_o,
    output logic [XLEN-1:0] rv2_o,
    output logic            busy_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     clr_ptr_q;
    logic [XLEN-1:0]   mem_q [NREG];

    logic              clr_last;
    logic              mem_we_d;
    logic [AW-1:0]     mem_waddr_d;
    logic [XLEN-1:0]   mem_wdata_d;
    logic              user_wr;

    assign busy_o   = (state_q == ST_CLEAR) || reset_i;
    assign clr_last = (clr_ptr_q == AW'(NREG - 1));
    assign user_wr  = !busy_o && we_i && (rd_i != '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= AW'(1);
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + AW'(1);
                    if (clr_last) begin
                        state_q <= ST_READY;
                    end
                end
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

    // A single shared write port: the clear sequence and user writes never overlap.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = clr_ptr_q;
        mem_wdata_d = '0;
        if (!reset_i && (state_q == ST_CLEAR)) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = clr_ptr_q;
            mem_wdata_d = '0;
        end else if (user_wr) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = rd_i;
            mem_wdata_d = wdata_i;
        end
    end

    // mem_q[0] is never written; address 0 is resolved in the read mux.
    always_ff @(posedge clk_i) begin
        if (mem_we_d && (mem_waddr_d != '0)) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   rs,
        input logic            busy,
        input logic            we,
        input logic [AW-1:0]   rd,
        input logic [XLEN-1:0] wdata,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] val;
        if (busy) begin
            val = '0;
        end else if (rs == '0) begin
            val = '0;
        end else if (BYPASS && we && (rd == rs)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    assign rv1_o = read_port(rs1_i, busy_o, we_i, rd_i, wdata_i, mem_q[rs1_i]);
    assign rv2_o = read_port(rs2_i, busy_o, we_i, rd_i, wdata_i, mem_q[rs2_i]);

endmodule
